// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline encodings: ALU ops, forwarding selects, result sources.
package riscv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_NONE = 3'b111
  } alu_op_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational RV32 integer ALU; results wrap, zero flag covers the full result.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [2:0]      i_op,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);

  logic w_lt_s;
  logic w_lt_u;

  assign w_lt_s = $signed(i_a) < $signed(i_b);
  assign w_lt_u = i_a < i_b;

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, w_lt_s};
      ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, w_lt_u};
      default:  o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/execute_stage.sv
// RV32 EX stage: operand forwarding, ALU, branch/jump resolution, PC target
// adder and the EX/MEM pipeline register.
module execute_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ExtImmE,
  input  logic [XLEN-1:0] PCPulse4E,
  input  logic [4:0]      RdE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPulse4M,
  output logic [4:0]      RdM
);

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd;
  } ex_mem_t;

  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_write_data;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_zero;
  ex_mem_t         w_ex_mem;
  ex_mem_t         r_ex_mem;

  // MEM-stage forwarding taps the registered result, so no loop through the ALU.
  always_comb begin
    w_src_a = RD1E;
    case (ForwardAE)
      FWD_WB:  w_src_a = ResultW;
      FWD_MEM: w_src_a = r_ex_mem.alu_result;
      default: w_src_a = RD1E;
    endcase
  end

  always_comb begin
    w_write_data = RD2E;
    case (ForwardBE)
      FWD_WB:  w_write_data = ResultW;
      FWD_MEM: w_write_data = r_ex_mem.alu_result;
      default: w_write_data = RD2E;
    endcase
  end

  assign w_src_b = ALUSrcE ? ExtImmE : w_write_data;

  alu #(.XLEN(XLEN)) u_alu (
    .i_a      (w_src_a),
    .i_b      (w_src_b),
    .i_op     (ALUControlE),
    .o_result (w_alu_result),
    .o_zero   (w_zero)
  );

  assign PCSrcE    = (BranchE & w_zero) | JumpE;
  assign PCTargetE = PCE + ExtImmE;

  always_comb begin
    w_ex_mem            = '0;
    w_ex_mem.reg_write  = RegWriteE;
    w_ex_mem.mem_write  = MemWriteE;
    w_ex_mem.result_src = ResultSrcE;
    w_ex_mem.alu_result = w_alu_result;
    w_ex_mem.write_data = w_write_data;
    w_ex_mem.pc_plus4   = PCPulse4E;
    w_ex_mem.rd         = RdE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ex_mem <= '0;
    else        r_ex_mem <= w_ex_mem;
  end

  assign RegWriteM  = r_ex_mem.reg_write;
  assign MemWriteM  = r_ex_mem.mem_write;
  assign ResultSrcM = r_ex_mem.result_src;
  assign ALUResultM = r_ex_mem.alu_result;
  assign WriteDataM = r_ex_mem.write_data;
  assign PCPulse4M  = r_ex_mem.pc_plus4;
  assign RdM        = r_ex_mem.rd;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage RV32 pipeline; consumes the ID/EX register outputs (E-suffixed signals).
- Contains the forwarding muxes, the ALU, branch/jump resolution and the PC target adder.
- Ends in the EX/MEM pipeline register that feeds the memory stage (M-suffixed outputs).
- PCSrcE, PCTargetE and the forwarded operands are combinational; everything else is registered with 1-cycle latency.

Parameters:
- XLEN, 32, datapath width (PC, operands, immediate, results).

Ports:
- clk  in  1  pipeline clock, posedge.
- rst_n  in  1  asynchronous active-low reset.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  in  1 each  control from ID/EX.
- ResultSrcE  in  2  00 ALU, 01 memory, 10 PC+4.
- ALUControlE  in  3  ALU op select.
- RD1E, RD2E, PCE, ExtImmE, PCPulse4E  in  XLEN each  data from ID/EX.
- RdE  in  5  destination register.
- ForwardAE, ForwardBE  in  2 each  from hazard unit: 00 RDxE, 01 ResultW, 10 ALUResultM, 11 reserved (treated as 00).
- ResultW  in  XLEN  writeback-stage result, used for forwarding.
- PCSrcE  out  1  combinational redirect: (BranchE & ZeroE) | JumpE.
- PCTargetE  out  XLEN  combinational PCE + ExtImmE, modulo 2^XLEN.
- RegWriteM, MemWriteM  out  1 each  registered control.
- ResultSrcM  out  2  registered control.
- ALUResultM, WriteDataM, PCPulse4M  out  XLEN each  registered data.
- RdM  out  5  registered destination register.

Behaviour:
- SrcAE = mux(ForwardAE) of RD1E / ResultW / ALUResultM.
- WriteDataE = mux(ForwardBE) of RD2E / ResultW / ALUResultM.
- SrcBE = ALUSrcE ? ExtImmE : WriteDataE.
- ALU ops (results wrap modulo 2^XLEN, no overflow flag):
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 xor
  - 101 slt (signed, result 1 or 0)
  - 110 sltu
  - 111 returns 0
- ZeroE = (ALUResultE == 0); comparison covers the full result for every op.
- ALUResultM is forwarded back into the stage from the register output, not the current-cycle ALU result; there is no combinational loop.
- EX/MEM register, every posedge clk: RegWriteM<=RegWriteE, ResultSrcM<=ResultSrcE, MemWriteM<=MemWriteE, ALUResultM<=ALUResultE, WriteDataM<=WriteDataE (forwarded value, not raw RD2E), RdM<=RdE, PCPulse4M<=PCPulse4E.
- Reset: rst_n low clears all M outputs to 0 immediately (asynchronous). Release takes effect on the next posedge.
- Reset mid-operation:
  - An in-flight store or regwrite is dropped: MemWriteM=0, RegWriteM=0.
  - PCSrcE remains combinational from its inputs. The upstream ID/EX reset zeroes JumpE/BranchE, so no redirect occurs during reset.
- No stall or flush inputs: bubbles arrive as zeroed control from ID/EX CLR, and the stage passes them unchanged (RegWriteM=0, MemWriteM=0).
- A flushed bubble with BranchE=0 and JumpE=0 never asserts PCSrcE, regardless of ZeroE.
- Jump with BranchE=0: PCSrcE=1. PCTargetE is produced for JAL; JALR target selection is outside this block.
- Simultaneous ForwardAE=10 and ForwardBE=01 is legal; each mux selects independently.

Decomposition:
- Shared package riscv_pkg holds:
  - ALU op encodings: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU.
  - Forward select constants: FWD_REG, FWD_WB, FWD_MEM.
  - ResultSrc constants: RES_ALU, RES_MEM, RES_PC4.
- One sub-module: alu (combinational, XLEN-parameterised, outputs result and zero).
- Muxes, target adder and EX/MEM register stay in execute_stage.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with RegWriteE=1 → all M outputs 0 without waiting for a clock edge. After release plus one posedge, outputs track the inputs.
- ALU/imm: RD1E=0x00000005, ExtImmE=0xFFFFFFFD, ALUSrcE=1, op 000 → ALUResultM=0x00000002 one cycle later. Repeat with op 101, RD1E=0xFFFFFFFF, RD2E=1, ALUSrcE=0 → ALUResultM=1; op 110 with the same operands → 0.
- Forwarding: ForwardAE=10 with ALUResultM=0x10; ForwardBE=01 with ResultW=0x3; op 001 → next ALUResultM=0x0000000D and WriteDataM=0x3 (RD2E ignored).
- Branch: BranchE=1, op 001, equal operands 0x7/0x7, PCE=0x100, ExtImmE=0xFFFFFFF0 → PCSrcE=1, PCTargetE=0x000000F0. With unequal operands → PCSrcE=0.
- Jump/bubble:
  - JumpE=1, ResultSrcE=10, PCPulse4E=0x204 → PCSrcE=1, then PCPulse4M=0x204 and ResultSrcM=10.
  - All-zero control bubble → RegWriteM=0, MemWriteM=0, PCSrcE=0.
- Wrap: PCE=0xFFFFFFFC, ExtImmE=8 → PCTargetE=0x00000004. Op 000 on 0xFFFFFFFF+1 → ALUResultM=0 with ZeroE=1.
